// File: rtl/simple_phase_sequencer.sv
// rtl/simple_phase_sequencer.sv - run/stop controller, P1..P5 phase enables and retired-instruction counter
// Optional single-instruction stepping is enabled by defining SIMPLE_PHASE_STEP_EN.
module simple_phase_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_exec,
    input  logic             i_halt_req,
`ifdef SIMPLE_PHASE_STEP_EN
    input  logic             i_step_mode,
`endif
    output logic [4:0]       o_phase_en,
    output logic             o_running,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_inst_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_P1   = 5'b00001;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_exec_prev;
    logic                   w_exec_pulse;
    logic                   w_step;
    logic                   w_stop_at_end;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_phase;
    logic [4:0]             w_phase_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;

`ifdef SIMPLE_PHASE_STEP_EN
    assign w_step = i_step_mode;
`else
    assign w_step = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync      <= '0;
            r_exec_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_exec};
            r_exec_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_exec_pulse = r_sync[SYNC_STAGES-1] & ~r_exec_prev;

    // A press at P5 toggles the pending stop just like a press in P1..P4.
    assign w_stop_at_end = w_step | ((r_state == S_STOPPING) ^ w_exec_pulse);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_phase <= PH_NONE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (w_exec_pulse) begin
                    w_state_nxt = S_RUN;
                    w_phase_nxt = PH_P1;
                end
            end
            S_RUN, S_STOPPING: begin
                if (r_phase[4]) begin
                    w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (i_halt_req) begin
                        w_state_nxt = S_HALTED;
                        w_phase_nxt = PH_NONE;
                    end else if (w_stop_at_end) begin
                        w_state_nxt = S_IDLE;
                        w_phase_nxt = PH_NONE;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_phase_nxt = PH_P1;
                    end
                end else begin
                    w_phase_nxt = r_phase << 1;
                    if (w_exec_pulse) begin
                        w_state_nxt = (r_state == S_RUN) ? S_STOPPING : S_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = PH_NONE;
            end
        endcase
    end

    always_comb begin
        o_phase_en   = r_phase;
        o_running    = (r_state == S_RUN) || (r_state == S_STOPPING);
        o_halted     = (r_state == S_HALTED);
        o_inst_count = r_count;
    end

endmodule
